dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 127 ++++++++++++
 tb/tb_dm_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory.
// Each access takes IDLE-sample, SERVE and ACK cycles; out-of-range addresses return ERR_CODE.
module dm_arbiter #(
  parameter int unsigned DEPTH    = 100,
  parameter logic [31:0] ERR_CODE = 32'h0000DEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        dm_memwrite,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gid_q, gid_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic        p0_err_q, p0_err_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        p1_err_q, p1_err_d;
  logic        grant;
  logic        in_range;

  assign in_range = (addr_q < DEPTH_W);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    p0_rdata_d   = p0_rdata_q;
    p0_err_d     = p0_err_q;
    p1_rdata_d   = p1_rdata_q;
    p1_err_d     = p1_err_q;
    grant        = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          // On contention the port that was not served last wins.
          grant        = (p0_req && p1_req) ? ~last_grant_q : p1_req;
          gid_d        = grant;
          last_grant_d = grant;
          we_d         = grant ? p1_we    : p0_we;
          addr_d       = grant ? p1_addr  : p0_addr;
          wdata_d      = grant ? p1_wdata : p0_wdata;
          state_d      = SERVE;
        end
      end
      SERVE: begin
        state_d = ACK;
        if (gid_q) begin
          p1_rdata_d = in_range ? dm_rd : ERR_CODE;
          p1_err_d   = ~in_range;
        end else begin
          p0_rdata_d = in_range ? dm_rd : ERR_CODE;
          p0_err_d   = ~in_range;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      p0_rdata_q   <= '0;
      p0_err_q     <= 1'b0;
      p1_rdata_q   <= '0;
      p1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      p0_rdata_q   <= p0_rdata_d;
      p0_err_q     <= p0_err_d;
      p1_rdata_q   <= p1_rdata_d;
      p1_err_q     <= p1_err_d;
    end
  end

  // Memory-side and ack outputs decode straight from state so reset clears them at once.
  assign dm_memwrite = (state_q == SERVE) && we_q && in_range;
  assign dm_addr     = addr_q;
  assign dm_wd       = wdata_q;
  assign busy        = (state_q != IDLE);
  assign p0_ack      = (state_q == ACK) && !gid_q;
  assign p1_ack      = (state_q == ACK) && gid_q;
  assign p0_rdata    = p0_rdata_q;
  assign p0_err      = p0_err_q;
  assign p1_rdata    = p1_rdata_q;
  assign p1_err      = p1_err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: requesters push expected responses, a monitor checks each ack.
module tb_dm_arbiter;

  logic        clk, rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        dm_memwrite, busy;
  logic [31:0] dm_addr, dm_wd, dm_rd;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          lat_a, lat_b;
  logic [31:0] mem [0:127];
  bit          mem_loaded = 1'b0;

  dm_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .dm_memwrite(dm_memwrite), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_rd(dm_rd),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] orig(input int i);
    return (i == 3) ? 32'h0 : (32'hC0DE0000 | 32'(i));
  endfunction

  // Memory model: combinational read, write on the rising edge when dm_memwrite is high.
  assign dm_rd = (dm_addr < 32'd128) ? mem[dm_addr[6:0]] : 32'h0BAD0BAD;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= orig(i);
      mem_loaded <= 1'b1;
    end else if (dm_memwrite && dm_addr < 32'd128) begin
      mem[dm_addr[6:0]] <= dm_wd;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per ack and counts write cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if (dm_memwrite) wr_cnt++;
      if (p0_ack && p1_ack) begin
        checkOutput("dual_ack", 32'd1, 32'd0);
      end else if (p0_ack || p1_ack) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("ack_port", {31'b0, p1_ack}, {31'b0, e.port});
          checkOutput("rdata", p1_ack ? p1_rdata : p0_rdata, e.rdata);
          checkOutput("err", {31'b0, p1_ack ? p1_err : p0_err}, {31'b0, e.err});
        end
      end
    end
  end

  task automatic request(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat);
    logic seen;
    @(negedge clk);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = port ? p1_ack : p0_ack;
    end
    if (!seen) checkOutput("ack_timeout", 32'd0, 32'd1);
    if (port) begin
      p1_req = 1'b0; p1_we = 1'b0;
    end else begin
      p0_req = 1'b0; p0_we = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err);
    int wr0;
    int lat;
    wr0 = wr_cnt;
    sb.push_back('{port, exp_rdata, exp_err});
    request(port, we, addr, wdata, lat);
    checkOutput("latency", 32'(lat), 32'd2);
    checkOutput("memwrite_cycles", 32'(wr_cnt - wr0), (we && addr < 32'd100) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_acks", {30'b0, p1_ack, p0_ack}, 32'd0);
    checkOutput("reset_memwrite", {31'b0, dm_memwrite}, 32'd0);
    checkOutput("reset_dm_addr", dm_addr, 32'd0);
    checkOutput("reset_dm_wd", dm_wd, 32'd0);
    checkOutput("reset_p0_rdata", p0_rdata, 32'd0);
    checkOutput("reset_p1_rdata", p1_rdata, 32'd0);
    checkOutput("reset_errs", {30'b0, p1_err, p0_err}, 32'd0);
    rst = 1'b0;

    $display("[TB] contention from reset");
    sb.push_back('{1'b0, orig(10), 1'b0});
    sb.push_back('{1'b1, orig(11), 1'b0});
    sb.push_back('{1'b0, orig(12), 1'b0});
    sb.push_back('{1'b1, orig(13), 1'b0});
    fork
      begin request(1'b0, 1'b0, 32'd10, 32'd0, lat_a); request(1'b0, 1'b0, 32'd12, 32'd0, lat_a); end
      begin request(1'b1, 1'b0, 32'd11, 32'd0, lat_b); request(1'b1, 1'b0, 32'd13, 32'd0, lat_b); end
    join

    $display("[TB] write then read addr 5");
    applyStimulus(1'b0, 1'b1, 32'd5, 32'h12345678, orig(5), 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd5, 32'h0, 32'h12345678, 1'b0);

    $display("[TB] read-during-write addr 3");
    applyStimulus(1'b0, 1'b1, 32'd3, 32'h1, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd3, 32'h0, 32'h1, 1'b0);

    $display("[TB] out-of-range write on p1");
    applyStimulus(1'b1, 1'b1, 32'd100, 32'hFFFF, 32'h0000DEAD, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd99, 32'h0, orig(99), 1'b0);
    checkOutput("mem100_untouched", mem[100], orig(100));
    checkOutput("p0_rdata_hold", p0_rdata, 32'h1);
    checkOutput("p0_err_hold", {31'b0, p0_err}, 32'd0);

    applyStimulus(1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0000DEAD, 1'b1);
    checkOutput("p1_rdata_hold", p1_rdata, orig(99));

    $display("[TB] reset during SERVE");
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd7; p0_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    checkOutput("serve_busy", {31'b0, busy}, 32'd1);
    checkOutput("serve_memwrite", {31'b0, dm_memwrite}, 32'd1);
    checkOutput("serve_dm_addr", dm_addr, 32'd7);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_memwrite", {31'b0, dm_memwrite}, 32'd0);
    checkOutput("abort_p0_ack", {31'b0, p0_ack}, 32'd0);
    checkOutput("abort_p0_rdata", p0_rdata, 32'd0);
    checkOutput("abort_p0_err", {31'b0, p0_err}, 32'd0);
    checkOutput("abort_dm_wd", dm_wd, 32'd0);
    @(negedge clk);
    p0_req = 1'b0; p0_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mem7_unchanged", mem[7], orig(7));
    checkOutput("idle_after_abort", {31'b0, busy}, 32'd0);

    sb.push_back('{1'b0, orig(20), 1'b0});
    sb.push_back('{1'b1, orig(21), 1'b0});
    fork
      request(1'b0, 1'b0, 32'd20, 32'd0, lat_a);
      request(1'b1, 1'b0, 32'd21, 32'd0, lat_b);
    join

    waited = 0;
    while (sb.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
